// File: rtl/pixel_fetch_if.sv
// Loader FIFO read port: show-ahead byte stream with a same-cycle pop strobe.
// master = frame loader side, slave = pixel_fetch side.
interface pixel_fetch_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_next;

    modport master (
        output i_valid,
        output i_data,
        input  o_next
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_next
    );
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch: overlays an IMG_W x IMG_H grayscale image, read from the loader's
// show-ahead FIFO, onto the raster at (X0,Y0) and drives registered RGB888 pixels.
// FIFO underrun keeps the window position-locked and emits a marker colour.
// Optional build macro PIXEL_FETCH_STATS_EN adds o_ur_cnt and o_frame_cnt.
module pixel_fetch #(
    parameter int unsigned IMG_W   = 225,
    parameter int unsigned IMG_H   = 225,
    parameter int unsigned X0      = 207,
    parameter int unsigned Y0      = 127,
    parameter int unsigned CNT_W   = 12,
    parameter logic [7:0]  BG_GRAY = 8'h00,
    parameter logic [23:0] UR_RGB  = 24'hFF00FF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic [CNT_W-1:0] i_x,
    input  logic [CNT_W-1:0] i_y,
    pixel_fetch_if.slave     fifo,
    output logic             o_de,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic             o_underrun
`ifdef PIXEL_FETCH_STATS_EN
    ,
    output logic [15:0]      o_ur_cnt,
    output logic [15:0]      o_frame_cnt
`endif
);

    localparam int unsigned CW    = CNT_W + 1;
    localparam int unsigned PIX_W = 16;

    localparam logic [CW-1:0]    X_LO     = CW'(X0);
    localparam logic [CW-1:0]    X_HI     = CW'(X0 + IMG_W);
    localparam logic [CW-1:0]    Y_LO     = CW'(Y0);
    localparam logic [CW-1:0]    Y_HI     = CW'(Y0 + IMG_H);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [PIX_W-1:0] pix_cnt_q;
    logic [PIX_W-1:0] pix_cnt_d;

    logic [CW-1:0] x_ext;
    logic [CW-1:0] y_ext;
    logic          in_win_c;
    logic          take_c;
    logic          fetch_c;
    logic          under_c;

    // Window decode and per-pixel fetch decision (ARMED takes its first window pixel itself).
    always_comb begin
        x_ext     = {1'b0, i_x};
        y_ext     = {1'b0, i_y};
        in_win_c  = i_de
                  & (x_ext >= X_LO) & (x_ext < X_HI)
                  & (y_ext >= Y_LO) & (y_ext < Y_HI);
        take_c    = i_vsync & in_win_c
                  & ((state_q == S_ACTIVE) | (state_q == S_ARMED));
        fetch_c   = take_c & fifo.i_valid;
        under_c   = take_c & ~fifo.i_valid;
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
    end

    // Pop only the byte actually consumed this cycle.
    assign fifo.o_next = fetch_c;

    // Frame FSM, position counter and registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            o_de       <= 1'b0;
            o_r        <= 8'h00;
            o_g        <= 8'h00;
            o_b        <= 8'h00;
            o_underrun <= 1'b0;
        end else begin
            o_de <= i_de;

            if (fetch_c) begin
                {o_r, o_g, o_b} <= {3{fifo.i_data}};
            end else if (under_c) begin
                {o_r, o_g, o_b} <= UR_RGB;
            end else begin
                {o_r, o_g, o_b} <= {3{BG_GRAY}};
            end

            if (!i_vsync) begin
                state_q    <= S_ARMED;
                pix_cnt_q  <= '0;
                o_underrun <= 1'b0;
            end else begin
                if (under_c) begin
                    o_underrun <= 1'b1;
                end
                if (take_c) begin
                    pix_cnt_q <= pix_cnt_d;
                    state_q   <= (pix_cnt_q == LAST_PIX) ? S_DONE : S_ACTIVE;
                end
            end
        end
    end

`ifdef PIXEL_FETCH_STATS_EN
    // Per-frame underrun tally (saturating) and completed-frame count (wrapping).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ur_cnt    <= '0;
            o_frame_cnt <= '0;
        end else begin
            if (!i_vsync) begin
                o_ur_cnt <= '0;
            end else begin
                if (under_c && (o_ur_cnt != 16'hFFFF)) begin
                    o_ur_cnt <= o_ur_cnt + 16'd1;
                end
                if (take_c && (pix_cnt_q == LAST_PIX)) begin
                    o_frame_cnt <= o_frame_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: two instances share one raster; instance 0 sees an
// always-valid FIFO, instance 1 sees a FIFO that runs dry on chosen pixels.
// The model tracks "window pixels consumed since the last vsync" per instance.
module tb_pixel_fetch;

    localparam int X0 = 207;
    localparam int Y0 = 127;
    localparam int W  = 225;
    localparam int H  = 225;
    localparam int N  = W * H;
    localparam logic [23:0] UR = 24'hFF00FF;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk;
    logic        rst_n;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;

    logic       vld [2];
    logic [7:0] dat [2];
    logic       nxt [2];
    logic       ode [2];
    logic [7:0] orr [2];
    logic [7:0] og  [2];
    logic [7:0] ob  [2];
    logic       our [2];
`ifdef PIXEL_FETCH_STATS_EN
    logic [15:0] ourc [2];
    logic [15:0] ofc  [2];
`endif

    pixel_fetch_if fif_a ();
    pixel_fetch_if fif_b ();

    assign fif_a.i_valid = vld[0];
    assign fif_a.i_data  = dat[0];
    assign nxt[0]        = fif_a.o_next;
    assign fif_b.i_valid = vld[1];
    assign fif_b.i_data  = dat[1];
    assign nxt[1]        = fif_b.o_next;

    pixel_fetch dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vsync    (vsync),
        .i_de       (de),
        .i_x        (x),
        .i_y        (y),
        .fifo       (fif_a),
        .o_de       (ode[0]),
        .o_r        (orr[0]),
        .o_g        (og[0]),
        .o_b        (ob[0]),
        .o_underrun (our[0])
`ifdef PIXEL_FETCH_STATS_EN
        ,
        .o_ur_cnt   (ourc[0]),
        .o_frame_cnt(ofc[0])
`endif
    );

    pixel_fetch dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vsync    (vsync),
        .i_de       (de),
        .i_x        (x),
        .i_y        (y),
        .fifo       (fif_b),
        .o_de       (ode[1]),
        .o_r        (orr[1]),
        .o_g        (og[1]),
        .o_b        (ob[1]),
        .o_underrun (our[1])
`ifdef PIXEL_FETCH_STATS_EN
        ,
        .o_ur_cnt   (ourc[1]),
        .o_frame_cnt(ofc[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    bit          armed;
    int          fp      [2];
    bit          m_ur    [2];
    int          m_urc   [2];
    int          m_frm   [2];
    logic        e_de;
    logic [23:0] e_rgb   [2];
    // loader FIFO model and bookkeeping
    int          fcnt    [2];
    int          tot_pop [2];
    bit          nx_s    [2];
    bit          ur_en;
    int          ur_y, ur_xlo, ur_xhi;
    bit          cap_en;
    logic [23:0] cap [2][512];
    int          px_p, py_p;
    bit          de_p;
    int          n_cmp, n_err;

    function automatic bit win();
        return de && int'(x) >= X0 && int'(x) < X0 + W && int'(y) >= Y0 && int'(y) < Y0 + H;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic model_rst();
        armed = 1'b0;
        e_de  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fp[d]    = 0;
            m_ur[d]  = 1'b0;
            m_urc[d] = 0;
            m_frm[d] = 0;
            e_rgb[d] = 24'h0;
        end
    endtask

    task automatic drive(input logic vs, input logic d_e, input int xx, input int yy);
        vsync = vs;
        de    = d_e;
        x     = 12'(xx);
        y     = 12'(yy);
        for (int d = 0; d < 2; d++) begin
            dat[d] = 8'(fcnt[d]);
            vld[d] = !(d == 1 && ur_en && d_e && yy == ur_y && xx >= ur_xlo && xx <= ur_xhi);
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, return #1 later.
    task automatic cycle();
        logic en;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            en = rst_n && vsync && armed && win() && fp[d] < N && vld[d];
            chk("o_next", d, 32'(nxt[d]), 32'(en));
            chk("o_de", d, 32'(ode[d]), 32'(e_de));
            chk("rgb", d, 32'({orr[d], og[d], ob[d]}), 32'(e_rgb[d]));
            chk("o_underrun", d, 32'(our[d]), 32'(m_ur[d]));
`ifdef PIXEL_FETCH_STATS_EN
            chk("o_ur_cnt", d, 32'(ourc[d]), 32'(16'(m_urc[d])));
            chk("o_frame_cnt", d, 32'(ofc[d]), 32'(16'(m_frm[d])));
`endif
            if (cap_en && de_p && py_p == 127 && px_p < 512) cap[d][px_p] = {orr[d], og[d], ob[d]};
            nx_s[d] = nxt[d];
        end
        @(posedge clk);
        if (rst_n) begin
            e_de = de;
            if (!vsync) begin
                armed = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    fp[d]    = 0;
                    m_ur[d]  = 1'b0;
                    m_urc[d] = 0;
                    e_rgb[d] = BG;
                    fcnt[d]  = 0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (armed && win() && fp[d] < N) begin
                        fp[d]++;
                        if (fp[d] == N) m_frm[d]++;
                        if (vld[d]) begin
                            e_rgb[d] = {3{dat[d]}};
                        end else begin
                            e_rgb[d] = UR;
                            m_ur[d]  = 1'b1;
                            if (m_urc[d] < 65535) m_urc[d]++;
                        end
                    end else begin
                        e_rgb[d] = BG;
                    end
                    if (nx_s[d]) begin
                        fcnt[d]++;
                        tot_pop[d]++;
                    end
                end
            end
        end
        px_p = int'(x);
        py_p = int'(y);
        de_p = de;
        #1;
    endtask

    task automatic line(input int yy, input int xa, input int xb);
        for (int xx = xa; xx <= xb; xx++) begin
            drive(1'b1, 1'b1, xx, yy);
            cycle();
        end
        drive(1'b1, 1'b0, 0, 0);
        cycle();
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b0, 0, 0);
        cycle();
        cycle();
        drive(1'b1, 1'b0, 0, 0);
        cycle();
    endtask

    task automatic clr_pops();
        for (int d = 0; d < 2; d++) tot_pop[d] = 0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        ur_en  = 1'b0;
        ur_y   = 0;
        ur_xlo = 0;
        ur_xhi = 0;
        cap_en = 1'b0;
        px_p   = 0;
        py_p   = 0;
        de_p   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fcnt[d]    = 0;
            tot_pop[d] = 0;
            nx_s[d]    = 1'b0;
        end
        rst_n = 1'b0;
        model_rst();
        drive(1'b1, 1'b0, 0, 0);
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            chk("reset_rgb", d, 32'({orr[d], og[d], ob[d]}), 32'h0);
            chk("reset_de", d, 32'(ode[d]), 32'h0);
        end
        rst_n = 1'b1;

        // raster without any vsync: nothing fetched
        clr_pops();
        for (int yy = 126; yy <= 128; yy++) line(yy, 200, 220);
        for (int d = 0; d < 2; d++) chk("pops_before_vsync", d, 32'(tot_pop[d]), 32'd0);

        // full frame; instance 1 runs dry on window pixels 100..103
        vs_pulse();
        clr_pops();
        ur_en = 1'b1; ur_y = 127; ur_xlo = 307; ur_xhi = 310;
        cap_en = 1'b1;
        for (int yy = 126; yy <= 352; yy++) line(yy, 205, 433);
        cap_en = 1'b0;
        ur_en  = 1'b0;
        chk("frame_pops", 0, 32'(tot_pop[0]), 32'd50625);
        chk("frame_pops", 1, 32'(tot_pop[1]), 32'd50621);
        chk("pix_207_127", 0, 32'(cap[0][207]), 32'h000000);
        chk("pix_208_127", 0, 32'(cap[0][208]), 32'h010101);
        chk("pix_311_127", 0, 32'(cap[0][311]), 32'h686868);
        chk("pix_306_127", 1, 32'(cap[1][306]), 32'h636363);
        for (int xx = 307; xx <= 310; xx++) chk("ur_pixel", 1, 32'(cap[1][xx]), 32'hFF00FF);
        chk("pix_311_127", 1, 32'(cap[1][311]), 32'h646464);
        chk("underrun_flag", 0, 32'(our[0]), 32'd0);
        chk("underrun_flag", 1, 32'(our[1]), 32'd1);
`ifdef PIXEL_FETCH_STATS_EN
        chk("ur_cnt_frame", 1, 32'(ourc[1]), 32'd4);
        chk("ur_cnt_frame", 0, 32'(ourc[0]), 32'd0);
        chk("frame_cnt", 0, 32'(ofc[0]), 32'd1);
`endif

        // frame complete: window pixels are no longer fetched
        clr_pops();
        line(200, 205, 220);
        for (int d = 0; d < 2; d++) chk("pops_after_done", d, 32'(tot_pop[d]), 32'd0);

        // vsync asserted in the middle of the window
        vs_pulse();
        ur_en = 1'b1; ur_y = 127; ur_xlo = 209; ur_xhi = 209;
        cap_en = 1'b1;
        for (int xx = 205; xx <= 216; xx++) begin
            drive(1'b1, 1'b1, xx, 127);
            cycle();
        end
        chk("ur_before_vs", 1, 32'(our[1]), 32'd1);
        drive(1'b0, 1'b1, 217, 127);
        #1;
        chk("next_at_vs", 0, 32'(nxt[0]), 32'd0);
        cycle();
        chk("ur_after_vs", 1, 32'(our[1]), 32'd0);
        for (int xx = 218; xx <= 230; xx++) begin
            drive(1'b1, 1'b1, xx, 127);
            cycle();
        end
        drive(1'b1, 1'b0, 0, 0);
        cycle();
        cap_en = 1'b0;
        ur_en  = 1'b0;
        chk("pix_216_f2", 0, 32'(cap[0][216]), 32'h090909);
        chk("pix_216_f2", 1, 32'(cap[1][216]), 32'h080808);
        chk("restart_218", 0, 32'(cap[0][218]), 32'h000000);
        chk("restart_219", 0, 32'(cap[0][219]), 32'h010101);

        // asynchronous reset in the middle of an active line
        for (int xx = 205; xx <= 209; xx++) begin
            drive(1'b1, 1'b1, xx, 128);
            cycle();
        end
        drive(1'b1, 1'b1, 210, 128);
        rst_n = 1'b0;
        model_rst();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_de", d, 32'(ode[d]), 32'd0);
            chk("async_rst_rgb", d, 32'({orr[d], og[d], ob[d]}), 32'h0);
            chk("async_rst_next", d, 32'(nxt[d]), 32'd0);
        end
        clr_pops();
        cycle();
        for (int xx = 211; xx <= 212; xx++) begin
            drive(1'b1, 1'b1, xx, 128);
            cycle();
        end
        rst_n = 1'b1;
        for (int xx = 213; xx <= 230; xx++) begin
            drive(1'b1, 1'b1, xx, 128);
            cycle();
        end
        drive(1'b1, 1'b0, 0, 0);
        cycle();
        line(129, 205, 230);
        for (int d = 0; d < 2; d++) chk("pops_after_reset", d, 32'(tot_pop[d]), 32'd0);

        // fetching resumes after the next vsync
        vs_pulse();
        clr_pops();
        line(127, 205, 212);
        for (int d = 0; d < 2; d++) chk("pops_resumed", d, 32'(tot_pop[d]), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
